// File: rtl/spi_byte_peripheral_pkg.sv
// Shared types and constants for the SPI byte peripheral.
package spi_byte_peripheral_pkg;

  // Byte shifted out on MISO when no response byte has been queued.
  localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;

  // Transaction state: IDLE while chip select is high, ACTIVE while it is low.
  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_t;

endpackage

// File: rtl/spi_byte_peripheral_if.sv
// SPI pin and byte-handshake bundle for spi_byte_peripheral.
// The tx_underrun flag exists only when SPI_TX_UNDERRUN_EN is defined.
interface spi_byte_peripheral_if;

  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_byte;
  logic       spi_tx_valid;
  logic [7:0] spi_tx_byte;
  logic       busy;
`ifdef SPI_TX_UNDERRUN_EN
  logic       tx_underrun;
`endif

  // Peripheral side: SPI pins and response strobe in, MISO and received bytes out.
  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    input  spi_tx_valid,
    input  spi_tx_byte,
    output spi_miso,
    output spi_miso_oe,
    output spi_rx_valid,
    output spi_rx_byte,
    output busy
`ifdef SPI_TX_UNDERRUN_EN
    , output tx_underrun
`endif
  );

  // Bus-master / system side: the mirror image of the peripheral.
  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    output spi_tx_valid,
    output spi_tx_byte,
    input  spi_miso,
    input  spi_miso_oe,
    input  spi_rx_valid,
    input  spi_rx_byte,
    input  busy
`ifdef SPI_TX_UNDERRUN_EN
    , input tx_underrun
`endif
  );

endinterface

// File: rtl/spi_byte_peripheral_input_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// SYNC_STAGES must be at least 2; RESET_VALUE is the level the chain holds in reset.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {SYNC_STAGES{RESET_VALUE}};
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_byte_peripheral.sv
// SPI mode-0 slave front end: oversamples SCK/CS_n/MOSI in the clk domain,
// assembles MSB-first bytes and serialises queued response bytes onto MISO.
// Optional sticky idle-fill flag under the SPI_TX_UNDERRUN_EN macro.
module spi_byte_peripheral
  import spi_byte_peripheral_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] IDLE_TX_BYTE = SPI_IDLE_BYTE
) (
  input logic                  clk,
  input logic                  rst,
  spi_byte_peripheral_if.slave bus
);

  // Synchronised pin levels.
  logic sck_s, cs_n_s, mosi_s;

  // Registered copies and edge strobes; the strobes and mosi_q share one vintage.
  logic sck_q, cs_n_q, mosi_q;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  spi_state_t state, next_state;

  logic [2:0] bit_count;
  logic [7:0] rx_shift;
  logic       byte_done;
  logic       rx_valid;
  logic [7:0] rx_byte;

  logic [7:0] tx_shift;
  logic [7:0] tx_buf;
  logic       tx_pending;

  logic       frame_start, frame_end, bit_rise, bit_fall;
  logic       boundary_load, tx_load;
  logic [7:0] load_byte;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(bus.spi_sck), .q(sck_s)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .d(bus.spi_cs_n), .q(cs_n_s)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.spi_mosi), .q(mosi_s)
  );

  // Detect edges on the synchronised SCK and CS_n and register them as one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sck_q    <= sck_s;
      cs_n_q   <= cs_n_s;
      mosi_q   <= mosi_s;
      sck_rise <= sck_s & ~sck_q;
      sck_fall <= ~sck_s & sck_q;
      cs_fall  <= ~cs_n_s & cs_n_q;
      cs_rise  <= cs_n_s & ~cs_n_q;
    end
  end

  // Transaction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: chip select edges alone move the FSM.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = ACTIVE;
      ACTIVE:  if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SCK edges count only inside a frame, and a CS_n rise in the same cycle wins.
  assign frame_start   = (state == IDLE)   && cs_fall;
  assign frame_end     = (state == ACTIVE) && cs_rise;
  assign bit_rise      = (state == ACTIVE) && !cs_rise && sck_rise;
  assign bit_fall      = (state == ACTIVE) && !cs_rise && sck_fall;
  assign boundary_load = bit_fall && (bit_count == 3'd0);
  assign tx_load       = frame_start || boundary_load;

  // A strobe arriving in the load cycle bypasses the buffer.
  assign load_byte = bus.spi_tx_valid ? bus.spi_tx_byte :
                     tx_pending       ? tx_buf          : IDLE_TX_BYTE;

  // Receive path: shift on SCK rise, deliver the completed byte one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count <= 3'd0;
      rx_shift  <= 8'h00;
      byte_done <= 1'b0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
    end else begin
      byte_done <= 1'b0;
      rx_valid  <= byte_done;
      if (byte_done) rx_byte <= rx_shift;
      if (frame_start || frame_end) begin
        bit_count <= 3'd0;
      end else if (bit_rise) begin
        rx_shift  <= {rx_shift[6:0], mosi_q};
        bit_count <= bit_count + 3'd1;
        byte_done <= (bit_count == 3'd7);
      end
    end
  end

  // Transmit path: reload at byte boundaries, shift on SCK fall, buffer queued responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift   <= 8'h00;
      tx_buf     <= 8'h00;
      tx_pending <= 1'b0;
    end else if (tx_load) begin
      tx_shift   <= load_byte;
      tx_pending <= 1'b0;
    end else begin
      if (bit_fall) tx_shift <= {tx_shift[6:0], 1'b0};
      if (bus.spi_tx_valid) begin
        tx_buf     <= bus.spi_tx_byte;
        tx_pending <= 1'b1;
      end
    end
  end

`ifdef SPI_TX_UNDERRUN_EN
  logic tx_underrun;

  // Sticky flag for an in-frame byte-boundary reload that fell back to the idle byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                      tx_underrun <= 1'b0;
    else if (frame_start)                                         tx_underrun <= 1'b0;
    else if (boundary_load && !bus.spi_tx_valid && !tx_pending)   tx_underrun <= 1'b1;
  end

  assign bus.tx_underrun = tx_underrun;
`endif

  assign bus.spi_miso     = tx_shift[7];
  assign bus.spi_miso_oe  = ~cs_n_s;
  assign bus.spi_rx_valid = rx_valid;
  assign bus.spi_rx_byte  = rx_byte;
  assign bus.busy         = (state == ACTIVE);

endmodule

// File: tb/tb_spi_byte_peripheral.sv
// Self-checking bench for spi_byte_peripheral: a pin-level SPI master drives
// frames and the results are compared against a byte-level response-queue model.
module tb_spi_byte_peripheral;
  import spi_byte_peripheral_pkg::*;

  localparam int S    = 2;
  localparam int HALF = 4;   // clk cycles per SCK half period (SCK = clk/8)

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  spi_byte_peripheral_if bus_if ();

  spi_byte_peripheral #(
    .SYNC_STAGES (S),
    .IDLE_TX_BYTE(SPI_IDLE_BYTE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  // Response model: one pending slot, last strobe wins, consumed at each load.
  logic [7:0] model_buf;
  bit         model_pending;
  logic [7:0] rx_seen[$];
  bit         busy_drop;

  always @(negedge clk) if (!rst && bus_if.spi_rx_valid) rx_seen.push_back(bus_if.spi_rx_byte);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] model_load();
    if (model_pending) begin
      model_pending = 1'b0;
      return model_buf;
    end
    return SPI_IDLE_BYTE;
  endfunction

  task automatic strobe_tx(input logic [7:0] b);
    bus_if.spi_tx_byte  = b;
    bus_if.spi_tx_valid = 1'b1;
    tick(1);
    bus_if.spi_tx_valid = 1'b0;
    model_buf     = b;
    model_pending = 1'b1;
  endtask

  task automatic cs_low();
    bus_if.spi_cs_n = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    bus_if.spi_cs_n = 1'b1;
    tick(4 * HALF);
  endtask

  // Shift nbits of b MSB-first; MISO is sampled at each SCK rise like a real master.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus_if.spi_mosi = b[7-i];
      tick(HALF);
      bus_if.spi_sck  = 1'b1;
      miso_b[7-i]     = bus_if.spi_miso;
      if (!bus_if.busy) busy_drop = 1'b1;
      tick(HALF);
      bus_if.spi_sck  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst                 = 1'b1;
    bus_if.spi_cs_n     = 1'b1;
    bus_if.spi_sck      = 1'b0;
    bus_if.spi_mosi     = 1'b0;
    bus_if.spi_tx_valid = 1'b0;
    bus_if.spi_tx_byte  = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2 * S + 2);
    model_pending = 1'b0;
    model_buf     = 8'h00;
    rx_seen.delete();
  endtask

  // One full CS frame of n bytes, checked for received bytes and MISO content.
  task automatic run_frame(input logic [7:0] bytes[8], input int n, input string name);
    logic [7:0] exp_miso[8];
    logic [7:0] got;
    rx_seen.delete();
    exp_miso[0] = model_load();
    cs_low();
    for (int k = 0; k < n; k++) begin
      xfer(bytes[k], 8, got);
      tests_run++;
      if (got !== exp_miso[k]) begin
        tests_failed++;
        $display("FAIL %s miso byte %0d: got %h expected %h", name, k, got, exp_miso[k]);
      end
      exp_miso[k+1] = model_load();
    end
    cs_high();
    tests_run++;
    if (rx_seen.size() != n) begin
      tests_failed++;
      $display("FAIL %s rx count: got %0d expected %0d", name, rx_seen.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        tests_run++;
        if (rx_seen[k] !== bytes[k]) begin
          tests_failed++;
          $display("FAIL %s rx byte %0d: got %h expected %h", name, k, rx_seen[k], bytes[k]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (bus_if.spi_miso !== 1'b0 || bus_if.spi_miso_oe !== 1'b0 || bus_if.spi_rx_valid !== 1'b0 ||
        bus_if.spi_rx_byte !== 8'h00 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: miso=%b oe=%b rx_valid=%b rx_byte=%h busy=%b expected 0 0 0 00 0", name,
               bus_if.spi_miso, bus_if.spi_miso_oe, bus_if.spi_rx_valid, bus_if.spi_rx_byte, bus_if.busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_rx_byte();
    logic [7:0] got;
    rx_seen.delete();
    busy_drop = 1'b0;
    cs_low();
    tests_run++;
    if (bus_if.busy !== 1'b1 || bus_if.spi_miso_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_byte busy/oe after cs fall: busy=%b oe=%b expected 1 1", bus_if.busy, bus_if.spi_miso_oe);
    end
    xfer(8'hA5, 8, got);
    tick(4 * HALF);
    tests_run++;
    if (busy_drop) begin
      tests_failed++;
      $display("FAIL rx_byte busy: got 0 during frame expected 1");
    end
    cs_high();
    tests_run++;
    if (rx_seen.size() != 1 || rx_seen[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL rx_byte: got %0d pulses first=%h expected 1 pulse a5", rx_seen.size(),
               (rx_seen.size() > 0) ? rx_seen[0] : 8'hxx);
    end
    tests_run++;
    if (bus_if.spi_rx_byte !== 8'hA5 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_byte hold: rx_byte=%h busy=%b expected a5 0", bus_if.spi_rx_byte, bus_if.busy);
    end
    void'(model_load());
    void'(model_load());
  endtask

  task automatic test_latency();
    logic [7:0] got;
    int         k;
    cs_low();
    xfer(8'h5A, 7, got);
    bus_if.spi_mosi = 1'b0;
    tick(HALF);
    bus_if.spi_sck = 1'b1;   // next posedge samples the 8th rise
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (bus_if.spi_rx_valid) break;
    end
    tests_run++;
    if (k - 1 != S + 2) begin
      tests_failed++;
      $display("FAIL rx_latency: got %0d clk edges expected %0d", k - 1, S + 2);
    end
    tick(HALF);
    bus_if.spi_sck = 1'b0;
    cs_high();
    tests_run++;
    if (bus_if.spi_rx_byte !== 8'h5A) begin
      tests_failed++;
      $display("FAIL rx_latency byte: got %h expected 5a", bus_if.spi_rx_byte);
    end
    void'(model_load());
    void'(model_load());
  endtask

  task automatic test_multi_byte();
    logic [7:0] bytes[8];
    bytes = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(bytes, 4, "multi_byte");
  endtask

  task automatic test_tx_response();
    logic [7:0] bytes[8];
    logic [7:0] m0, m1, e0, e1;
    int         k;
    bytes = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    strobe_tx(8'hC3);
    run_frame(bytes, 2, "tx_preload");
    // Second frame: response queued only after the first byte is received.
    rx_seen.delete();
    e0 = model_load();
    cs_low();
    k = 0;
    fork
      begin
        xfer(8'h33, 8, m0);
        xfer(8'h44, 8, m1);
      end
      begin
        while (k < 400 && !bus_if.spi_rx_valid) begin @(negedge clk); k++; end
        bus_if.spi_tx_byte  = 8'h7E;
        bus_if.spi_tx_valid = 1'b1;
        @(negedge clk);
        bus_if.spi_tx_valid = 1'b0;
        model_buf     = 8'h7E;
        model_pending = 1'b1;
      end
    join
    e1 = model_load();
    void'(model_load());
    cs_high();
    tests_run++;
    if (k >= 400) begin
      tests_failed++;
      $display("FAIL tx_midframe: no rx_valid within 400 cycles");
    end
    tests_run++;
    if (m0 !== e0 || m1 !== e1) begin
      tests_failed++;
      $display("FAIL tx_midframe miso: got %h %h expected %h %h", m0, m1, e0, e1);
    end
  endtask

  task automatic test_last_wins();
    logic [7:0] bytes[8];
    bytes = '{8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    strobe_tx(8'h4B);
    tick(2);
    strobe_tx(8'hD2);
    run_frame(bytes, 1, "last_wins");
  endtask

  task automatic test_abort();
    logic [7:0] bytes[8];
    logic [7:0] got;
    rx_seen.delete();
    cs_low();
    xfer(8'hFF, 5, got);
    cs_high();
    void'(model_load());
    tests_run++;
    if (rx_seen.size() != 0) begin
      tests_failed++;
      $display("FAIL abort partial: got %0d pulses expected 0", rx_seen.size());
    end
    bytes = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(bytes, 1, "abort_next");
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes[8];
    logic [7:0] got;
    cs_low();
    xfer(8'hF0, 4, got);
    rst             = 1'b1;
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_sck  = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    tick(3);
    rst = 1'b0;
    tick(2 * S + 2);
    model_pending = 1'b0;
    model_buf     = 8'h00;
    bytes = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(bytes, 1, "reset_mid_next");
  endtask

  task automatic test_random_frames();
    logic [7:0] bytes[8];
    int         n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) bytes[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) strobe_tx(8'($urandom));
      if ($urandom_range(0, 1) == 1) strobe_tx(8'($urandom));
      run_frame(bytes, n, $sformatf("random_frame_%0d", f));
    end
  endtask

`ifdef SPI_TX_UNDERRUN_EN
  task automatic test_underrun();
    logic [7:0] got;
    strobe_tx(8'hE1);
    cs_low();
    tests_run++;
    if (bus_if.tx_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun first load: got %b expected 0", bus_if.tx_underrun);
    end
    xfer(8'h10, 8, got);
    tick(HALF);
    tests_run++;
    if (bus_if.tx_underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun set: got %b expected 1", bus_if.tx_underrun);
    end
    xfer(8'h20, 8, got);
    cs_high();
    cs_low();
    tests_run++;
    if (bus_if.tx_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun clear: got %b expected 0", bus_if.tx_underrun);
    end
    cs_high();
    model_pending = 1'b0;
  endtask
`endif

  initial begin
    rst                 = 1'b1;
    bus_if.spi_cs_n     = 1'b1;
    bus_if.spi_sck      = 1'b0;
    bus_if.spi_mosi     = 1'b0;
    bus_if.spi_tx_valid = 1'b0;
    bus_if.spi_tx_byte  = 8'h00;
    model_pending       = 1'b0;
    model_buf           = 8'h00;
    busy_drop           = 1'b0;
    test_reset();
    test_rx_byte();
    test_latency();
    test_multi_byte();
    test_tx_response();
    test_last_wins();
    test_abort();
    test_reset_mid();
    test_random_frames();
`ifdef SPI_TX_UNDERRUN_EN
    test_underrun();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
